// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO-PUF frequency compare stage and its
// challenge sequencer: FSM state encoding, default sizing and a width helper.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } puf_state_t;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WINDOW = 1024;
  localparam int DEF_SETTLE = 3;

  // Bits needed to hold 0..n, never less than one bit so a zero-length
  // phase still produces a legal vector.
  function automatic int ctr_w(input int n);
    ctr_w = (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One oscillator channel: 2-flop synchroniser, edge flop, rising-edge
// detect and a saturating edge counter gated by the measurement window.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ro,
  output logic [CNT_W-1:0] cnt
);

  logic s1, s2, s3;
  logic rise;

  // Synchroniser plus edge flop; free-running so a fresh mux selection
  // flushes through before the window opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ro;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Count rises only inside the window; stick at all-ones so an overrange
  // oscillator still compares sensibly (two saturated channels tie).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && rise && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ro_puf_freq_compare.sv
// RO-PUF frequency compare: measures rising edges of two selected ring
// oscillators over a fixed window and reports which one ran faster.
module ro_puf_freq_compare
  import ro_puf_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             busy,
  output logic             resp_valid,
  output logic             resp_bit,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int WIN_W = ctr_w(WINDOW);
  localparam int SET_W = ctr_w(SETTLE);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  puf_state_t       state, state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [SET_W-1:0] set_cnt;
  logic             accept;
  logic             a_gt, a_eq;
  logic             bit_q, tie_q;

  // start is only honoured from IDLE; anything else is dropped, not queued.
  assign accept = (state == ST_IDLE) && start;

  // State register; reset from any state, mid-window included.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> SETTLE -> COUNT -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (SETTLE > 0) ? ST_SETTLE : ST_COUNT;
      ST_SETTLE: if (set_cnt == SET_LAST) state_nxt = ST_COUNT;
      ST_COUNT:  if (win_cnt == WIN_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Phase timers; each sits at zero outside its own state so it starts
  // fresh on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_cnt <= '0;
      win_cnt <= '0;
    end else begin
      set_cnt <= (state == ST_SETTLE) ? set_cnt + SET_W'(1) : '0;
      win_cnt <= (state == ST_COUNT)  ? win_cnt + WIN_W'(1) : '0;
    end
  end

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == ST_COUNT),
    .ro  (ro_a),
    .cnt (count_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == ST_COUNT),
    .ro  (ro_b),
    .cnt (count_b)
  );

  assign a_gt = count_a > count_b;
  assign a_eq = count_a == count_b;

  // Result latch: captured in DONE from the final counts, held until the
  // next accepted start clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= 1'b0;
      tie_q <= 1'b0;
    end else if (accept) begin
      bit_q <= 1'b0;
      tie_q <= 1'b0;
    end else if (state == ST_DONE) begin
      bit_q <= a_gt;
      tie_q <= a_eq;
    end
  end

  // Counts are final on entry to DONE, so the compare is presented straight
  // from the count registers in that cycle and from the latch afterwards.
  assign resp_valid = (state == ST_DONE);
  assign busy       = (state == ST_SETTLE) || (state == ST_COUNT);
  assign resp_bit   = (state == ST_DONE) ? a_gt : bit_q;
  assign tie        = (state == ST_DONE) ? a_eq : tie_q;

endmodule

// File: tb/tb_ro_puf_freq_compare.sv
// Directed bench for ro_puf_freq_compare: WINDOW=64, SETTLE=3, with a
// second CNT_W=4 instance sharing the stimulus for the saturation case.
module tb_ro_puf_freq_compare;

  localparam int WIN = 64;
  localparam int SET = 3;
  localparam int LAT = SET + WIN + 1;

  logic        clk = 1'b0;
  logic        rst, start, ro_a, ro_b;
  logic        busy, resp_valid, resp_bit, tie;
  logic [15:0] count_a, count_b;
  logic        busy1, rv1, rb1, tie1;
  logic [3:0]  ca1, cb1;

  int total = 0;
  int bad   = 0;
  int per_a = 0;
  int per_b = 0;
  int tick  = 0;

  ro_puf_freq_compare #(.CNT_W(16), .WINDOW(WIN), .SETTLE(SET)) dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .busy(busy), .resp_valid(resp_valid), .resp_bit(resp_bit), .tie(tie),
    .count_a(count_a), .count_b(count_b)
  );

  ro_puf_freq_compare #(.CNT_W(4), .WINDOW(WIN), .SETTLE(SET)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .busy(busy1), .resp_valid(rv1), .resp_bit(rb1), .tie(tie1),
    .count_a(ca1), .count_b(cb1)
  );

  always #5 clk = ~clk;

  // Oscillator models: square waves in clk periods, phase-aligned to tick.
  initial begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    forever begin
      @(negedge clk);
      tick++;
      ro_a = (per_a > 0) && ((tick % per_a) < (per_a / 2));
      ro_b = (per_b > 0) && ((tick % per_b) < (per_b / 2));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // One measurement: start at edge k, then observe cycles k+1 .. k+LAT+30.
  // Extra start pulses at p1..p3 and a one-cycle reset at p_rst (0 = none).
  task automatic run(input int p1, input int p2, input int p3, input int p_rst,
                     output int lat, output int nval, output int busy_late,
                     output int busy_first, output int done_busy,
                     output int cap_a, output int cap_b,
                     output int cap_bit, output int cap_tie);
    int quiet_from;
    lat = -1; nval = 0; busy_late = 0; busy_first = 0; done_busy = 0;
    cap_a = 0; cap_b = 0; cap_bit = 0; cap_tie = 0;
    quiet_from = (p_rst > 0) ? p_rst : LAT;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= LAT + 30; n++) begin
      @(negedge clk);
      if (n == 1) busy_first = busy;
      if (resp_valid) begin
        nval++;
        if (lat < 0) begin
          lat = n; done_busy = busy;
          cap_a = count_a; cap_b = count_b;
          cap_bit = resp_bit; cap_tie = tie;
        end
      end
      if (n > quiet_from && busy) busy_late++;
      if (p_rst > 0 && n == p_rst + 1) begin
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cnt_a", count_a, 0);
        chk("rst_mid_cnt_b", count_b, 0);
      end
      start = (n == p1) || (n == p2) || (n == p3);
      rst   = (n == p_rst);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  int lat, nval, bl, bf, db, ca, cb, cbit, ctie;

  initial begin
    rst = 1'b1; start = 1'b1;
    per_a = 4; per_b = 6;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
    end
    chk("rst_cnt_a", count_a, 0);
    chk("rst_cnt_b", count_b, 0);
    chk("rst_bit", resp_bit, 0);
    chk("rst_tie", tie, 0);
    chk("rst_sat_cnt", {ca1, cb1}, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    // A faster
    per_a = 4; per_b = 8;
    run(0, 0, 0, 0, lat, nval, bl, bf, db, ca, cb, cbit, ctie);
    chk("a_lat", lat, LAT);
    chk("a_nval", nval, 1);
    chk("a_busy_first", bf, 1);
    chk("a_done_busy", db, 0);
    chk("a_cnt_a", in_rng(ca, 15, 17), 1);
    chk("a_cnt_b", in_rng(cb, 7, 9), 1);
    chk("a_bit", cbit, 1);
    chk("a_tie", ctie, 0);
    chk("a_held_bit", resp_bit, 1);
    chk("a_held_cnt_a", in_rng(count_a, 15, 17), 1);

    // B faster
    per_a = 8; per_b = 4;
    run(0, 0, 0, 0, lat, nval, bl, bf, db, ca, cb, cbit, ctie);
    chk("b_lat", lat, LAT);
    chk("b_cnt_a", in_rng(ca, 7, 9), 1);
    chk("b_cnt_b", in_rng(cb, 15, 17), 1);
    chk("b_bit", cbit, 0);
    chk("b_tie", ctie, 0);

    // phase-aligned tie
    per_a = 8; per_b = 8;
    run(0, 0, 0, 0, lat, nval, bl, bf, db, ca, cb, cbit, ctie);
    chk("tie_eq", ca == cb, 1);
    chk("tie_cnt", in_rng(ca, 7, 9), 1);
    chk("tie_bit", cbit, 0);
    chk("tie_flag", ctie, 1);

    // saturation on the narrow instance
    per_a = 2; per_b = 2;
    run(0, 0, 0, 0, lat, nval, bl, bf, db, ca, cb, cbit, ctie);
    chk("sat_cnt_a", ca1, 15);
    chk("sat_cnt_b", cb1, 15);
    chk("sat_tie", tie1, 1);
    chk("sat_bit", rb1, 0);
    chk("sat_wide_cnt", in_rng(ca, 31, 33), 1);
    chk("sat_wide_tie", ctie, 1);

    // start pulses in SETTLE, mid-COUNT and DONE are all dropped
    per_a = 4; per_b = 8;
    run(2, 30, LAT, 0, lat, nval, bl, bf, db, ca, cb, cbit, ctie);
    chk("ign_lat", lat, LAT);
    chk("ign_nval", nval, 1);
    chk("ign_busy_late", bl, 0);
    chk("ign_bit", cbit, 1);

    // reset at window cycle 30
    run(0, 0, 0, SET + 30, lat, nval, bl, bf, db, ca, cb, cbit, ctie);
    chk("rst_mid_nval", nval, 0);
    chk("rst_mid_busy_late", bl, 0);

    // recovery after mid-window reset
    run(0, 0, 0, 0, lat, nval, bl, bf, db, ca, cb, cbit, ctie);
    chk("rec_lat", lat, LAT);
    chk("rec_nval", nval, 1);
    chk("rec_cnt_a", in_rng(ca, 15, 17), 1);
    chk("rec_cnt_b", in_rng(cb, 7, 9), 1);
    chk("rec_bit", cbit, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
